escalonador_esteira: RTL and testbench

ESCALONADOR_ESTEIRA -- requirements
Module: escalonador_esteira

---
 rtl/esteira_pkg.sv | 22 ++
 rtl/temporizador_avanco.sv | 40 ++++
 rtl/escalonador_esteira.sv | 161 ++++++++++++++++
 tb/tb_escalonador_esteira.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/esteira_pkg.sv
// Shared definitions for the bottling-line belt scheduler: state encodings,
// station indices and a small state-classification helper.
package esteira_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    OPERAR = 3'b001,
    SAIR   = 3'b010,
    CHEGAR = 3'b011,
    ALARME = 3'b100
  } estado_t;

  localparam int ENCH  = 0;
  localparam int CQ    = 1;
  localparam int LACRE = 2;

  // True while the belt is being advanced (motor requested).
  function automatic logic movendo(input estado_t e);
    return (e == SAIR) || (e == CHEGAR);
  endfunction

endpackage

// File: rtl/temporizador_avanco.sv
// Belt-advance watchdog: counts ticks while enabled and flags when the
// advance has taken TIMEOUT_TICKS ticks.
module temporizador_avanco #(
  parameter int TIMEOUT_TICKS = 200,
  parameter int W_TMO         = 8
) (
  input  logic clk,
  input  logic Reset,
  input  logic tick,
  input  logic clr,
  input  logic en,
  output logic expirou
);

  localparam logic [W_TMO-1:0] LIMITE = W_TMO'(TIMEOUT_TICKS - 1);
  localparam logic [W_TMO-1:0] UM     = W_TMO'(1);

  logic [W_TMO-1:0] cnt_r;

  // Tick counter; saturates so a stuck enable never wraps back below the limit.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      cnt_r <= '0;
    end else if (tick) begin
      if (clr) begin
        cnt_r <= '0;
      end else if (en && (cnt_r != '1)) begin
        cnt_r <= cnt_r + UM;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry fires on the tick whose increment would reach TIMEOUT_TICKS.
  assign expirou = en & (cnt_r >= LIMITE);

endmodule

// File: rtl/escalonador_esteira.sv
// Belt scheduler: grants the three stations, advances the belt once all
// occupied stations are done, tracks occupancy and raises a stall alarm.
module escalonador_esteira
  import esteira_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 200,
  parameter int W_TMO         = 8
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       Start,
  input  logic       Nova_Garrafa,
  input  logic [2:0] Fim_Estacao,
  input  logic       Descarte,
  input  logic       Sensor_Ativado,
  output logic       Comando_Mover_Esteira,
  output logic [2:0] Grant,
  output logic [2:0] Ocupacao,
  output logic       Garrafa_Saiu,
  output logic       Alarme_Timeout,
  output logic [2:0] Estado
);

  estado_t    state_r, state_nxt_s;
  logic [2:0] ocup_r, ocup_nxt_s;
  logic [2:0] feito_r, feito_nxt_s;
  logic       rej_r, rej_nxt_s;
  logic       saiu_nxt_s;
  logic [2:0] grant_r, grant_nxt_s;
  logic       mover_r, mover_nxt_s;
  logic       alarme_r, alarme_nxt_s;
  logic       saiu_r;
  logic       expirou_s, clr_s, en_s;

  assign en_s  = movendo(state_r);
  assign clr_s = (state_r == OPERAR) && (state_nxt_s == SAIR);

  temporizador_avanco #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .W_TMO        (W_TMO)
  ) u_tmr (
    .clk    (clk),
    .Reset  (Reset),
    .tick   (tick),
    .clr    (clr_s),
    .en     (en_s),
    .expirou(expirou_s)
  );

  // State and line bookkeeping registers, updated only on tick.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_r <= IDLE;
      ocup_r  <= 3'b000;
      feito_r <= 3'b000;
      rej_r   <= 1'b0;
    end else if (tick) begin
      state_r <= state_nxt_s;
      ocup_r  <= ocup_nxt_s;
      feito_r <= feito_nxt_s;
      rej_r   <= rej_nxt_s;
    end else begin
      state_r <= state_r;
      ocup_r  <= ocup_r;
      feito_r <= feito_r;
      rej_r   <= rej_r;
    end
  end

  // Next-state and bookkeeping logic; grant_r mirrors the live grant in OPERAR.
  always_comb begin
    state_nxt_s = state_r;
    ocup_nxt_s  = ocup_r;
    feito_nxt_s = feito_r;
    rej_nxt_s   = rej_r;
    saiu_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) state_nxt_s = OPERAR;
        else       state_nxt_s = IDLE;
      end
      OPERAR: begin
        feito_nxt_s = feito_r | (Fim_Estacao & grant_r);
        if (Fim_Estacao[CQ] && grant_r[CQ]) rej_nxt_s = Descarte;
        else                                rej_nxt_s = rej_r;
        if (!Start && (ocup_r == 3'b000)) begin
          state_nxt_s = IDLE;
        end else if ((grant_r == 3'b000) && ((ocup_r != 3'b000) || Nova_Garrafa)) begin
          state_nxt_s = SAIR;
        end else begin
          state_nxt_s = OPERAR;
        end
      end
      SAIR: begin
        if (expirou_s)            state_nxt_s = ALARME;
        else if (!Sensor_Ativado) state_nxt_s = CHEGAR;
        else                      state_nxt_s = SAIR;
      end
      CHEGAR: begin
        if (expirou_s) begin
          state_nxt_s = ALARME;
        end else if (Sensor_Ativado) begin
          // A bottle rejected at CQ is dropped instead of moving to lacre.
          ocup_nxt_s  = {ocup_r[CQ] & ~rej_r, ocup_r[ENCH], Nova_Garrafa};
          feito_nxt_s = 3'b000;
          rej_nxt_s   = 1'b0;
          saiu_nxt_s  = ocup_r[LACRE];
          state_nxt_s = OPERAR;
        end else begin
          state_nxt_s = CHEGAR;
        end
      end
      ALARME: begin
        state_nxt_s = ALARME;
      end
      default: begin
        state_nxt_s = IDLE;
        ocup_nxt_s  = 3'b000;
        feito_nxt_s = 3'b000;
        rej_nxt_s   = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track Estado.
  always_comb begin
    if (state_nxt_s == OPERAR) grant_nxt_s = ocup_nxt_s & ~feito_nxt_s;
    else                       grant_nxt_s = 3'b000;
    mover_nxt_s  = movendo(state_nxt_s);
    alarme_nxt_s = (state_nxt_s == ALARME);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      grant_r  <= 3'b000;
      mover_r  <= 1'b0;
      alarme_r <= 1'b0;
      saiu_r   <= 1'b0;
    end else if (tick) begin
      grant_r  <= grant_nxt_s;
      mover_r  <= mover_nxt_s;
      alarme_r <= alarme_nxt_s;
      saiu_r   <= saiu_nxt_s;
    end else begin
      grant_r  <= grant_r;
      mover_r  <= mover_r;
      alarme_r <= alarme_r;
      saiu_r   <= saiu_r;
    end
  end

  assign Comando_Mover_Esteira = mover_r;
  assign Grant                 = grant_r;
  assign Ocupacao              = ocup_r;
  assign Garrafa_Saiu          = saiu_r;
  assign Alarme_Timeout        = alarme_r;
  assign Estado                = state_r;

endmodule

// File: tb/tb_escalonador_esteira.sv
// Directed bench for escalonador_esteira with TIMEOUT_TICKS=4; inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
module tb_escalonador_esteira;

  logic       clk = 1'b0;
  logic       Reset, tick, Start, Nova_Garrafa, Descarte, Sensor_Ativado;
  logic [2:0] Fim_Estacao;
  logic       Comando_Mover_Esteira, Garrafa_Saiu, Alarme_Timeout;
  logic [2:0] Grant, Ocupacao, Estado;
  int checks = 0;
  int errors = 0;

  escalonador_esteira #(.TIMEOUT_TICKS(4), .W_TMO(8)) dut (
    .clk(clk), .Reset(Reset), .tick(tick), .Start(Start),
    .Nova_Garrafa(Nova_Garrafa), .Fim_Estacao(Fim_Estacao), .Descarte(Descarte),
    .Sensor_Ativado(Sensor_Ativado), .Comando_Mover_Esteira(Comando_Mover_Esteira),
    .Grant(Grant), .Ocupacao(Ocupacao), .Garrafa_Saiu(Garrafa_Saiu),
    .Alarme_Timeout(Alarme_Timeout), .Estado(Estado)
  );

  always #5 clk = ~clk;

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; tick = 1'b1; Start = 1'b0; Nova_Garrafa = 1'b0;
    Fim_Estacao = 3'b000; Descarte = 1'b0; Sensor_Ativado = 1'b1;
    ciclo(); ciclo();
    checks++; if ({Estado, Grant, Ocupacao, Comando_Mover_Esteira, Garrafa_Saiu, Alarme_Timeout} !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h expected 000", {Estado, Grant, Ocupacao, Comando_Mover_Esteira, Garrafa_Saiu, Alarme_Timeout}); end
    Reset = 1'b1;
    ciclo();
    checks++; if (Estado !== 3'b000) begin errors++; $display("FAIL idle_sem_start: got %b expected 000", Estado); end
  endtask

  task automatic test_primeira_garrafa();
    Start = 1'b1; Nova_Garrafa = 1'b1;
    ciclo();
    checks++; if ({Estado, Grant} !== 6'b001_000) begin errors++; $display("FAIL start_operar: got %b expected 001000", {Estado, Grant}); end
    ciclo();
    checks++; if ({Estado, Comando_Mover_Esteira} !== 4'b010_1) begin errors++; $display("FAIL linha_vazia_ng_sair: got %b expected 0101", {Estado, Comando_Mover_Esteira}); end
    Start = 1'b0; Sensor_Ativado = 1'b1;
    ciclo();
    checks++; if (Estado !== 3'b010) begin errors++; $display("FAIL sair_espera_sensor: got %b expected 010", Estado); end
    Sensor_Ativado = 1'b0;
    ciclo();
    checks++; if ({Estado, Comando_Mover_Esteira, Grant} !== 7'b011_1_000) begin errors++; $display("FAIL chegar: got %b expected 0111000", {Estado, Comando_Mover_Esteira, Grant}); end
    Sensor_Ativado = 1'b1;
    ciclo();
    checks++; if ({Estado, Ocupacao, Grant, Garrafa_Saiu, Comando_Mover_Esteira} !== 11'b001_001_001_0_0) begin errors++; $display("FAIL primeira_garrafa: got %b expected 00100100100", {Estado, Ocupacao, Grant, Garrafa_Saiu, Comando_Mover_Esteira}); end
    ciclo();
    checks++; if (Estado !== 3'b001) begin errors++; $display("FAIL start0_ocupada_fica: got %b expected 001", Estado); end
    Start = 1'b1;
  endtask

  task automatic test_rejeicao();
    Fim_Estacao = 3'b001; ciclo(); Fim_Estacao = 3'b000;
    ciclo();
    checks++; if (Estado !== 3'b010) begin errors++; $display("FAIL feito_sair: got %b expected 010", Estado); end
    Sensor_Ativado = 1'b0; ciclo(); Sensor_Ativado = 1'b1; ciclo();
    checks++; if ({Ocupacao, Grant} !== 6'b011_011) begin errors++; $display("FAIL ocup_011: got %b expected 011011", {Ocupacao, Grant}); end
    Fim_Estacao = 3'b011; ciclo(); Fim_Estacao = 3'b000; ciclo();
    Sensor_Ativado = 1'b0; ciclo(); Sensor_Ativado = 1'b1; ciclo();
    checks++; if ({Ocupacao, Grant, Garrafa_Saiu} !== 7'b111_111_0) begin errors++; $display("FAIL ocup_111: got %b expected 1111110", {Ocupacao, Grant, Garrafa_Saiu}); end
    Nova_Garrafa = 1'b0;
    Fim_Estacao = 3'b001; ciclo(); Fim_Estacao = 3'b000;
    checks++; if ({Estado, Grant} !== 6'b001_110) begin errors++; $display("FAIL fim_ench: got %b expected 001110", {Estado, Grant}); end
    Fim_Estacao = 3'b100; ciclo(); Fim_Estacao = 3'b000;
    checks++; if ({Estado, Grant} !== 6'b001_010) begin errors++; $display("FAIL fim_lacre: got %b expected 001010", {Estado, Grant}); end
    Fim_Estacao = 3'b010; Descarte = 1'b1; ciclo(); Fim_Estacao = 3'b000; Descarte = 1'b0;
    checks++; if ({Estado, Grant} !== 6'b001_000) begin errors++; $display("FAIL fim_cq_descarte: got %b expected 001000", {Estado, Grant}); end
    ciclo();
    checks++; if ({Estado, Comando_Mover_Esteira, Grant} !== 7'b010_1_000) begin errors++; $display("FAIL todos_feitos_sair: got %b expected 0101000", {Estado, Comando_Mover_Esteira, Grant}); end
    Sensor_Ativado = 1'b0; ciclo(); Sensor_Ativado = 1'b1; ciclo();
    checks++; if ({Ocupacao, Garrafa_Saiu} !== 4'b010_1) begin errors++; $display("FAIL rejeitada_descartada: got %b expected 0101", {Ocupacao, Garrafa_Saiu}); end
    ciclo();
    checks++; if ({Estado, Garrafa_Saiu} !== 4'b001_0) begin errors++; $display("FAIL saiu_um_tick: got %b expected 0010", {Estado, Garrafa_Saiu}); end
  endtask

  task automatic test_fim_sem_ocupacao();
    Fim_Estacao = 3'b100; ciclo(); Fim_Estacao = 3'b000;
    checks++; if ({Estado, Grant} !== 6'b001_010) begin errors++; $display("FAIL fim_lacre_vazia: got %b expected 001010", {Estado, Grant}); end
    Fim_Estacao = 3'b101; ciclo(); Fim_Estacao = 3'b000;
    ciclo();
    checks++; if ({Estado, Grant} !== 6'b001_010) begin errors++; $display("FAIL fim_nao_concedido: got %b expected 001010", {Estado, Grant}); end
    tick = 1'b0; Fim_Estacao = 3'b010; ciclo(); Fim_Estacao = 3'b000; tick = 1'b1;
    ciclo();
    checks++; if ({Estado, Grant} !== 6'b001_010) begin errors++; $display("FAIL fim_sem_tick: got %b expected 001010", {Estado, Grant}); end
    Fim_Estacao = 3'b010; ciclo(); Fim_Estacao = 3'b000;
    checks++; if (Grant !== 3'b000) begin errors++; $display("FAIL fim_cq_concedido: got %b expected 000", Grant); end
    ciclo();
    checks++; if (Estado !== 3'b010) begin errors++; $display("FAIL cq_feito_sair: got %b expected 010", Estado); end
  endtask

  task automatic test_timeout();
    tick = 1'b0; Sensor_Ativado = 1'b0; ciclo(); ciclo();
    checks++; if (Estado !== 3'b010) begin errors++; $display("FAIL sensor_sem_tick: got %b expected 010", Estado); end
    tick = 1'b1; Sensor_Ativado = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      ciclo();
      checks++; if (Estado !== 3'b010) begin errors++; $display("FAIL timeout_antes_%0d: got %b expected 010", i, Estado); end
    end
    ciclo();
    checks++; if ({Estado, Alarme_Timeout, Comando_Mover_Esteira, Grant} !== 8'b100_1_0_000) begin errors++; $display("FAIL alarme: got %b expected 10010000", {Estado, Alarme_Timeout, Comando_Mover_Esteira, Grant}); end
    Start = 1'b0; ciclo(); Start = 1'b1; Sensor_Ativado = 1'b0; ciclo(); ciclo();
    checks++; if ({Estado, Alarme_Timeout} !== 4'b100_1) begin errors++; $display("FAIL alarme_retido: got %b expected 1001", {Estado, Alarme_Timeout}); end
  endtask

  task automatic test_reset_chegar();
    Reset = 1'b0; ciclo(); Reset = 1'b1;
    checks++; if ({Estado, Alarme_Timeout} !== 4'b000_0) begin errors++; $display("FAIL reset_limpa_alarme: got %b expected 0000", {Estado, Alarme_Timeout}); end
    Start = 1'b1; Nova_Garrafa = 1'b1; Sensor_Ativado = 1'b1;
    ciclo(); ciclo();
    Sensor_Ativado = 1'b0; ciclo(); Sensor_Ativado = 1'b1; ciclo();
    Fim_Estacao = 3'b001; ciclo(); Fim_Estacao = 3'b000; ciclo();
    Sensor_Ativado = 1'b0; ciclo();
    checks++; if ({Estado, Ocupacao} !== 6'b011_001) begin errors++; $display("FAIL pre_reset_chegar: got %b expected 011001", {Estado, Ocupacao}); end
    Reset = 1'b0; tick = 1'b0; Sensor_Ativado = 1'b1; ciclo();
    checks++; if ({Estado, Comando_Mover_Esteira, Ocupacao, Grant, Garrafa_Saiu} !== 11'b0) begin errors++; $display("FAIL reset_em_chegar: got %b expected 00000000000", {Estado, Comando_Mover_Esteira, Ocupacao, Grant, Garrafa_Saiu}); end
    Reset = 1'b1; tick = 1'b1;
  endtask

  task automatic test_linha_vazia();
    Nova_Garrafa = 1'b0; Start = 1'b1;
    ciclo(); ciclo(); ciclo();
    checks++; if ({Estado, Comando_Mover_Esteira} !== 4'b001_0) begin errors++; $display("FAIL vazia_fica_operar: got %b expected 0010", {Estado, Comando_Mover_Esteira}); end
    Start = 1'b0; ciclo();
    checks++; if (Estado !== 3'b000) begin errors++; $display("FAIL vazia_start0_idle: got %b expected 000", Estado); end
  endtask

  initial begin
    test_reset();
    test_primeira_garrafa();
    test_rejeicao();
    test_fim_sem_ocupacao();
    test_timeout();
    test_reset_chegar();
    test_linha_vazia();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
